// File: rtl/riscv_zero_decode.sv
// riscv_zero_decode: RV32I decode stage with a single valid/stall/flush pipeline register toward execute.
module riscv_zero_decode #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     d_inst_data,
  input  logic [XLEN-1:0] d_pc,
  input  logic            d_valid,
  output logic            d_ready,
  input  logic            flush,
  input  logic            e_stall,
  output logic            e_valid,
  output logic [XLEN-1:0] e_pc,
  output logic [4:0]      e_rs1,
  output logic [4:0]      e_rs2,
  output logic [4:0]      e_rd,
  output logic [31:0]     e_imm,
  output logic [2:0]      e_funct3,
  output logic            e_funct7b5,
  output logic [3:0]      e_op_class,
  output logic            e_reg_write,
  output logic            e_illegal
);
  localparam logic [3:0] C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3,
    C_BRANCH = 4'd4, C_LOAD = 4'd5, C_STORE = 4'd6, C_OPIMM = 4'd7, C_OP = 4'd8,
    C_FENCE = 4'd9, C_SYSTEM = 4'd10, C_ILL = 4'd15;
  logic [31:0] inst;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [3:0]  opc_cls, cls;
  logic        bad, u_j, i_t, s_b;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        rw, f7b5;
  assign inst = d_inst_data;
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign d_ready = !e_stall | !e_valid;
  // The full 7-bit opcode is matched, so inst[1:0]!=2'b11 falls into the default.
  always_comb begin
    case (inst[6:0])
      7'h37:   opc_cls = C_LUI;
      7'h17:   opc_cls = C_AUIPC;
      7'h6F:   opc_cls = C_JAL;
      7'h67:   opc_cls = C_JALR;
      7'h63:   opc_cls = C_BRANCH;
      7'h03:   opc_cls = C_LOAD;
      7'h23:   opc_cls = C_STORE;
      7'h13:   opc_cls = C_OPIMM;
      7'h33:   opc_cls = C_OP;
      7'h0F:   opc_cls = C_FENCE;
      7'h73:   opc_cls = C_SYSTEM;
      default: opc_cls = C_ILL;
    endcase
  end
  always_comb begin
    bad = opc_cls == C_ILL
      | (opc_cls == C_LOAD & (f3 == 3'd3 | f3 == 3'd6 | f3 == 3'd7))
      | (opc_cls == C_STORE & f3 > 3'd2)
      | (opc_cls == C_BRANCH & (f3 == 3'd2 | f3 == 3'd3))
      | (opc_cls == C_JALR & f3 != 3'd0)
      | (opc_cls == C_OP & ((f7 != 7'h00 & f7 != 7'h20) | (f7 == 7'h20 & f3 != 3'd0 & f3 != 3'd5)))
      | (opc_cls == C_OPIMM & ((f3 == 3'd1 & f7 != 7'h00) | (f3 == 3'd5 & f7 != 7'h00 & f7 != 7'h20)));
    cls = bad ? C_ILL : opc_cls;
    u_j = cls == C_LUI | cls == C_AUIPC | cls == C_JAL;
    i_t = cls == C_JALR | cls == C_LOAD | cls == C_OPIMM | cls == C_FENCE | cls == C_SYSTEM;
    s_b = cls == C_BRANCH | cls == C_STORE;
    rs1 = (bad | u_j) ? 5'd0 : inst[19:15];
    rs2 = (bad | u_j | i_t) ? 5'd0 : inst[24:20];
    rd = (bad | s_b) ? 5'd0 : inst[11:7];
    imm = (bad | cls == C_OP) ? 32'd0 :
      (cls == C_LUI | cls == C_AUIPC) ? {inst[31:12], 12'b0} :
      cls == C_JAL ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
      cls == C_BRANCH ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
      cls == C_STORE ? {{21{inst[31]}}, inst[30:25], inst[11:7]} :
      {{21{inst[31]}}, inst[30:20]};
    rw = (u_j | cls == C_JALR | cls == C_LOAD | cls == C_OPIMM | cls == C_OP) & rd != 5'd0;
    f7b5 = inst[30] & (cls == C_OP | (cls == C_OPIMM & (f3 == 3'd1 | f3 == 3'd5)));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_valid <= 1'b0;
      e_pc <= RESET_PC;
      e_rs1 <= '0;
      e_rs2 <= '0;
      e_rd <= '0;
      e_imm <= '0;
      e_funct3 <= '0;
      e_funct7b5 <= 1'b0;
      e_op_class <= '0;
      e_reg_write <= 1'b0;
      e_illegal <= 1'b0;
    end else if (flush) begin
      e_valid <= 1'b0;
    end else if (d_ready) begin
      e_valid <= d_valid;
      if (d_valid) begin
        e_pc <= d_pc;
        e_rs1 <= rs1;
        e_rs2 <= rs2;
        e_rd <= rd;
        e_imm <= imm;
        e_funct3 <= f3;
        e_funct7b5 <= f7b5;
        e_op_class <= cls;
        e_reg_write <= rw;
        e_illegal <= bad;
      end
    end
  end
endmodule

// File: tb/tb_riscv_zero_decode.sv
// tb_riscv_zero_decode: directed vector table plus stall, flush and reset sequences for riscv_zero_decode.
module tb_riscv_zero_decode;
  localparam logic [31:0] RPC = 32'h0000_0100;
  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7b5, rw, ill;
  } vec_t;
  logic clk = 0, reset = 0, d_valid = 0, flush = 0, e_stall = 0;
  logic [31:0] d_inst_data = 0, d_pc = 0;
  logic d_ready, e_valid, e_funct7b5, e_reg_write, e_illegal;
  logic [31:0] e_pc, e_imm;
  logic [4:0] e_rs1, e_rs2, e_rd;
  logic [2:0] e_funct3;
  logic [3:0] e_op_class;
  int checks = 0, errors = 0;
  vec_t v[14];
  vec_t zero_v, addi_v, lw_v;
  riscv_zero_decode #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .d_inst_data(d_inst_data), .d_pc(d_pc), .d_valid(d_valid),
    .d_ready(d_ready), .flush(flush), .e_stall(e_stall), .e_valid(e_valid), .e_pc(e_pc),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_imm(e_imm), .e_funct3(e_funct3),
    .e_funct7b5(e_funct7b5), .e_op_class(e_op_class), .e_reg_write(e_reg_write),
    .e_illegal(e_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_out(input string tag, input vec_t e, input logic ev, input logic [31:0] epc);
    chk({tag, " valid"}, 32'(e_valid), 32'(ev));
    chk({tag, " pc"}, e_pc, epc);
    chk({tag, " class"}, 32'(e_op_class), 32'(e.cls));
    chk({tag, " rs1"}, 32'(e_rs1), 32'(e.rs1));
    chk({tag, " rs2"}, 32'(e_rs2), 32'(e.rs2));
    chk({tag, " rd"}, 32'(e_rd), 32'(e.rd));
    chk({tag, " imm"}, e_imm, e.imm);
    chk({tag, " funct3"}, 32'(e_funct3), 32'(e.f3));
    chk({tag, " funct7b5"}, 32'(e_funct7b5), 32'(e.f7b5));
    chk({tag, " reg_write"}, 32'(e_reg_write), 32'(e.rw));
    chk({tag, " illegal"}, 32'(e_illegal), 32'(e.ill));
  endtask
  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    d_inst_data = inst;
    d_pc = pc;
    d_valid = 1;
  endtask
  initial begin
    //          inst          cls  rs1 rs2 rd  imm            f3 f7b5 rw ill
    v[0]  = '{32'h00500093, 4'd7,  1'd0, 5'd0, 5'd1, 32'h00000005, 3'd0, 1'b0, 1'b1, 1'b0};
    v[1]  = '{32'h0080A103, 4'd5,  5'd1, 5'd0, 5'd2, 32'h00000008, 3'd2, 1'b0, 1'b1, 1'b0};
    v[2]  = '{32'h0020A623, 4'd6,  5'd1, 5'd2, 5'd0, 32'h0000000C, 3'd2, 1'b0, 1'b0, 1'b0};
    v[3]  = '{32'hFE208CE3, 4'd4,  5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 3'd0, 1'b0, 1'b0, 1'b0};
    v[4]  = '{32'h001000EF, 4'd2,  5'd0, 5'd0, 5'd1, 32'h00000800, 3'd0, 1'b0, 1'b1, 1'b0};
    v[5]  = '{32'hABCD12B7, 4'd0,  5'd0, 5'd0, 5'd5, 32'hABCD1000, 3'd1, 1'b0, 1'b1, 1'b0};
    v[6]  = '{32'hABCD1234, 4'd15, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'd1, 1'b0, 1'b0, 1'b1};
    v[7]  = '{32'h4000F033, 4'd15, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'd7, 1'b0, 1'b0, 1'b1};
    v[8]  = '{32'h402081B3, 4'd8,  5'd1, 5'd2, 5'd3, 32'h00000000, 3'd0, 1'b1, 1'b1, 1'b0};
    v[9]  = '{32'h4030D213, 4'd7,  5'd1, 5'd0, 5'd4, 32'h00000403, 3'd5, 1'b1, 1'b1, 1'b0};
    v[10] = '{32'h000010E7, 4'd15, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'd1, 1'b0, 1'b0, 1'b1};
    v[11] = '{32'h00000073, 4'd10, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0};
    v[12] = '{32'h00000013, 4'd7,  5'd0, 5'd0, 5'd0, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0};
    v[13] = '{32'h0000B023, 4'd15, 5'd0, 5'd0, 5'd0, 32'h00000000, 3'd3, 1'b0, 1'b0, 1'b1};
    zero_v = '{32'h0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0};
    addi_v = v[0];
    lw_v = v[1];
    reset = 0;
    tick();
    tick();
    check_out("reset", zero_v, 1'b0, RPC);
    chk("reset d_ready", 32'(d_ready), 32'd1);
    reset = 1;
    for (int i = 0; i < 14; i++) begin
      present(v[i].inst, 32'h1000 + 32'(i) * 4);
      tick();
      check_out($sformatf("vec%0d", i), v[i], 1'b1, 32'h1000 + 32'(i) * 4);
    end
    d_valid = 0;
    tick();
    chk("idle valid", 32'(e_valid), 32'd0);
    chk("idle rd hold", 32'(e_rd), 32'(v[13].rd));
    chk("idle funct3 hold", 32'(e_funct3), 32'(v[13].f3));
    present(addi_v.inst, 32'h2000);
    tick();
    e_stall = 1;
    present(lw_v.inst, 32'h2004);
    #1;
    chk("stall d_ready", 32'(d_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("stall%0d", i), addi_v, 1'b1, 32'h2000);
      chk($sformatf("stall%0d d_ready", i), 32'(d_ready), 32'd0);
    end
    e_stall = 0;
    #1;
    chk("unstall d_ready", 32'(d_ready), 32'd1);
    tick();
    check_out("after stall", lw_v, 1'b1, 32'h2004);
    e_stall = 1;
    flush = 1;
    present(addi_v.inst, 32'h3000);
    tick();
    chk("flush valid", 32'(e_valid), 32'd0);
    chk("flush d_ready", 32'(d_ready), 32'd1);
    flush = 0;
    e_stall = 0;
    present(v[8].inst, 32'h3004);
    tick();
    check_out("post flush", v[8], 1'b1, 32'h3004);
    flush = 1;
    present(v[9].inst, 32'h3008);
    tick();
    chk("flush drop valid", 32'(e_valid), 32'd0);
    flush = 0;
    d_valid = 0;
    tick();
    chk("flush drop stays empty", 32'(e_valid), 32'd0);
    present(v[5].inst, 32'h4000);
    tick();
    check_out("pre reset", v[5], 1'b1, 32'h4000);
    reset = 0;
    e_stall = 1;
    flush = 1;
    present(v[4].inst, 32'h4004);
    tick();
    check_out("mid reset", zero_v, 1'b0, RPC);
    chk("mid reset d_ready", 32'(d_ready), 32'd1);
    reset = 1;
    e_stall = 0;
    flush = 0;
    tick();
    check_out("after reset", v[4], 1'b1, 32'h4004);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
